// File: rtl/alu_op_sequencer_if.sv
// Command, load, ALU-side and result signals of the ALU operation sequencer.
// The master side issues commands and stands in for the ALU; the slave side is the sequencer.
interface alu_op_sequencer_if #(
  parameter int N  = 32,
  parameter int AW = 3
);
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [N-1:0]  ld_data;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_op;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [AW-1:0] cmd_rd;

  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [4:0]    alu_op;
  logic [N-1:0]  alu_out;
  logic [3:0]    alu_s;

  logic          res_valid;
  logic [N-1:0]  res_data;
  logic [3:0]    res_flags;
  logic          busy;

  modport master (
    output ld_valid, ld_addr, ld_data,
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_s,
    input  res_valid, res_data, res_flags, busy
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_s,
    output res_valid, res_data, res_flags, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Four-state front end for the combinational ALU: reads operands from a small register
// file, drives the ALU from registers, captures its result and writes it back.
module alu_op_sequencer #(
  parameter int N    = 32,
  parameter int REGS = 8,
  parameter int AW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_op_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          load_en;

  logic [4:0]    op_q;
  logic [AW-1:0] rs1_q;
  logic [AW-1:0] rs2_q;
  logic [AW-1:0] rd_q;
  logic [N-1:0]  rf [REGS];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A pending load always wins over a command in IDLE.
  always_comb begin
    bus.cmd_ready = (state == IDLE) && !bus.ld_valid;
    accept        = (state == IDLE) && !bus.ld_valid && bus.cmd_valid;
    load_en       = (state == IDLE) && bus.ld_valid;
  end

  // NOTE: the register file is cleared by reset, so it is built from flops with a
  // reset loop rather than mapped onto a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_op    <= '0;
      bus.res_data  <= '0;
      bus.res_flags <= '0;
      bus.res_valid <= 1'b0;
      bus.busy      <= 1'b0;
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
    end else begin
      bus.res_valid <= (state_nxt == WB);
      bus.busy      <= (state_nxt != IDLE);

      if (accept) begin
        op_q  <= bus.cmd_op;
        rs1_q <= bus.cmd_rs1;
        rs2_q <= bus.cmd_rs2;
        rd_q  <= bus.cmd_rd;
      end

      if (state == READ) begin
        bus.alu_a  <= rf[rs1_q];
        bus.alu_b  <= rf[rs2_q];
        bus.alu_op <= op_q;
      end

      if (state == EXEC) begin
        bus.res_data  <= bus.alu_out;
        bus.res_flags <= bus.alu_s;
      end

      // Loads only happen in IDLE and write-back only in WB, so they never collide.
      if (load_en)          rf[bus.ld_addr] <= bus.ld_data;
      else if (state == WB) rf[rd_q]        <= bus.res_data;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a stand-in ALU
// (OR for opcode 00100, add otherwise; status driven directly by the bench).
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_s_drv;
  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;
  int         hs_cyc = 0;
  int         hs_prev = 0;

  alu_op_sequencer_if #(.N(32), .AW(3)) bus ();

  alu_op_sequencer #(.N(32), .REGS(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.alu_out = (bus.alu_op == 5'b00100) ? (bus.alu_a | bus.alu_b)
                                                : (bus.alu_a + bus.alu_b);
  assign bus.alu_s   = alu_s_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] addr, input logic [31:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    #1 check("load_ready_low", bus.cmd_ready, 1'b0);
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  // Handshake at the current negedge's cycle, then walk READ/EXEC/WB/IDLE.
  task automatic run_cmd(input logic [4:0] op, input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [2:0] rd, input logic [3:0] s, input logic [31:0] ea,
                         input logic [31:0] eb, input logic [31:0] er, input bit ld_busy);
    alu_s_drv     = s;
    bus.cmd_op    = op;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    bus.cmd_rd    = rd;
    bus.cmd_valid = 1'b1;
    #1 check("hs_ready", bus.cmd_ready, 1'b1);
    hs_prev = hs_cyc;
    hs_cyc  = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("read_busy", bus.busy, 1'b1);
    if (ld_busy) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 3'd1;
      bus.ld_data  = 32'hFF;
    end
    @(negedge clk);
    check("exec_alu_a", bus.alu_a, ea);
    check("exec_alu_b", bus.alu_b, eb);
    check("exec_alu_op", bus.alu_op, op);
    check("exec_rv", bus.res_valid, 1'b0);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    check("wb_rv", bus.res_valid, 1'b1);
    check("wb_data", bus.res_data, er);
    check("wb_flags", bus.res_flags, s);
    @(negedge clk);
    check("idle_rv", bus.res_valid, 1'b0);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_ready", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    alu_s_drv = 4'b0000;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0;
    bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.cmd_ready, 1'b1);
    check("rst_rv", bus.res_valid, 1'b0);
    check("rst_alu_a", bus.alu_a, 32'h0);
    check("rst_alu_op", bus.alu_op, 5'h0);
    check("rst_res_data", bus.res_data, 32'h0);
    check("rst_res_flags", bus.res_flags, 4'h0);

    // Abandon a command with a two-cycle reset during EXEC.
    @(negedge clk);
    load(3'd1, 32'd9);
    alu_s_drv = 4'b1111;
    bus.cmd_op = 5'b00000; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd1; bus.cmd_rd = 3'd2;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_alu_a", bus.alu_a, 32'd9);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rv", bus.res_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rv2", bus.res_valid, 1'b0);
    #1;
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_ready", bus.cmd_ready, 1'b1);
    check("post_rst_data", bus.res_data, 32'h0);
    check("post_rst_alu_a", bus.alu_a, 32'h0);
    for (int r = 0; r < 8; r++)
      run_cmd(5'b00000, 3'(r), 3'd0, 3'(r), 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0);

    // Add path followed immediately by a dependent command.
    load(3'd1, 32'd5);
    load(3'd2, 32'd3);
    run_cmd(5'b00000, 3'd1, 3'd2, 3'd3, 4'b0010, 32'd5, 32'd3, 32'h8, 1'b0);
    run_cmd(5'b00000, 3'd3, 3'd3, 3'd4, 4'b0000, 32'd8, 32'd8, 32'h10, 1'b0);
    check("hs_spacing", hs_cyc - hs_prev, 32'd4);
    run_cmd(5'b00000, 3'd3, 3'd0, 3'd3, 4'b0000, 32'd8, 32'd0, 32'd8, 1'b0);
    run_cmd(5'b00000, 3'd4, 3'd0, 3'd4, 4'b0000, 32'd16, 32'd0, 32'd16, 1'b0);

    // Load and command in the same IDLE cycle: load wins, command goes next cycle.
    bus.ld_valid = 1'b1; bus.ld_addr = 3'd5; bus.ld_data = 32'hA;
    bus.cmd_op = 5'b00000; bus.cmd_rs1 = 3'd5; bus.cmd_rs2 = 3'd0; bus.cmd_rd = 3'd6;
    bus.cmd_valid = 1'b1;
    #1 check("coll_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    check("coll_busy", bus.busy, 1'b0);
    run_cmd(5'b00000, 3'd5, 3'd0, 3'd6, 4'b1000, 32'hA, 32'h0, 32'hA, 1'b0);

    // Loads while busy are dropped; r1 still holds 5.
    run_cmd(5'b00000, 3'd0, 3'd0, 3'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1);
    run_cmd(5'b00100, 3'd1, 3'd0, 3'd7, 4'b0101, 32'd5, 32'd0, 32'd5, 1'b0);

    // Results and operands hold while idle, even with changing ALU status.
    alu_s_drv = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rv", bus.res_valid, 1'b0);
    end
    check("hold_data", bus.res_data, 32'd5);
    check("hold_flags", bus.res_flags, 4'b0101);
    check("hold_alu_a", bus.alu_a, 32'd5);
    check("hold_alu_b", bus.alu_b, 32'd0);
    check("hold_busy", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequential front end for the combinational 32-bit ALU. It accepts register-to-register commands over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's `a`/`b`/`opCode` inputs from registers, captures the ALU's `out` and `S` results, and writes the result back to the register file. It sits directly upstream of the ALU and also consumes the ALU's outputs.

## Interface
Parameters:
- `N`, 32: datapath width; must equal the ALU's `N`.
- `REGS`, 8: register-file depth.
- `AW`, 3: register address width, equal to log2(`REGS`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ld_valid`  in  1  load request: write `ld_data` into `ld_addr`.
- `ld_addr`  in  AW  load target register.
- `ld_data`  in  N  load value.
- `cmd_valid`  in  1  ALU command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  5  opcode, passed unchanged to the ALU.
- `cmd_rs1`, `cmd_rs2`, `cmd_rd`  in  AW each  source and destination registers.
- `alu_a`, `alu_b`  out  N  registered operands to the ALU.
- `alu_op`  out  5  registered opcode to the ALU.
- `alu_out`  in  N  ALU result.
- `alu_s`  in  4  ALU status `{co, neg, over, zero}`.
- `res_valid`  out  1  one-cycle pulse at write-back.
- `res_data`  out  N  last captured result; held until the next capture.
- `res_flags`  out  4  last captured status; held until the next capture.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - `ld_valid` has priority. If `ld_valid` is high, the register write happens and `cmd_ready` is low that cycle.
  - Otherwise `cmd_ready` = 1. On handshake, latch `cmd_op`, `cmd_rs1`, `cmd_rs2`, `cmd_rd` and go to READ.
- READ: `alu_a` <= `rf[rs1]`, `alu_b` <= `rf[rs2]`, `alu_op` <= latched op. Go to EXEC.
- EXEC: the ALU output settles combinationally from the registered inputs. At the end of the cycle, `res_data` <= `alu_out` and `res_flags` <= `alu_s`. Go to WB.
- WB:
  - `rf[rd]` <= `res_data`; `res_valid` = 1 for exactly this cycle.
  - Go to IDLE.
- `ld_valid` outside IDLE is ignored; no write occurs. Loads are only guaranteed when `busy` = 0.
- `rs1 == rs2 == rd` is legal. Both operands read the pre-write value; rd is overwritten in WB.
- A command that reads the previous command's rd sees the written-back value, because WB completes before IDLE.
- No opcode decode. Opcodes the ALU treats as default (add) are passed through unchanged.
- `alu_a`, `alu_b`, `alu_op` hold their values from READ until the next READ.
- Register-file contents are unaffected by `cmd_ready`/`cmd_valid` activity except through WB.

## Timing
- Reset, on a clock edge with `rst` = 1:
  - state = IDLE; all register-file entries = 0.
  - `alu_a`, `alu_b`, `alu_op`, `res_data`, `res_flags` = 0.
  - `res_valid` = 0, `busy` = 0.
  - `cmd_ready` = 1 from the first cycle after reset, unless `ld_valid` is high that cycle.
- `rst` overrides everything, including mid-operation:
  - An in-flight command is abandoned with no register-file write and no `res_valid`.
  - A load in the same cycle as `rst` is dropped.
- Latency, with the handshake in cycle 0:
  - READ in cycle 1, EXEC in cycle 2, WB in cycle 3 (`res_valid` = 1).
  - IDLE in cycle 4, with `cmd_ready` = 1.
- Throughput: one command per 4 cycles.
- A load takes effect at the edge ending its IDLE cycle and is visible to a command accepted in the next cycle.
- `cmd_ready` is combinational: (state == IDLE) && !`ld_valid`. All other outputs are registered.

## Test plan
- Reset/idle: assert `rst` for 2 cycles mid-command (during EXEC).
  - After release: `busy` = 0, `cmd_ready` = 1, `res_valid` never pulsed.
  - Reading r0..r7 via ADD commands returns 0.
- Add path: load r1 = 5, r2 = 3; issue op `5'b00000`, rs1 = 1, rs2 = 2, rd = 3.
  - `alu_a` = 5 and `alu_b` = 3 in EXEC.
  - `res_valid` in cycle 3; `res_data` = 0x00000008; `res_flags` = 4'b0010.
  - r3 = 8 afterwards.
- Back-to-back dependency: issue op `00000` with rs1 = 3, rs2 = 3, rd = 4 in the same cycle `cmd_ready` rises after the previous test.
  - Expect `res_data` = 0x00000010 and r4 = 16.
  - Handshakes are exactly 4 cycles apart.
- Load/command collision: in IDLE, assert `ld_valid` (r5 = 0xA) and `cmd_valid` together.
  - `cmd_ready` = 0 that cycle; r5 = 0xA.
  - The command is accepted the following cycle.
- Ignored load: assert `ld_valid` r1 = 0xFF while `busy` = 1.
  - r1 keeps its value of 5, checked via OR with r0 (op `00100`): `res_data` = 5.
- Hold behaviour: keep `cmd_valid` = 0 for 10 cycles after a result.
  - `res_data`, `res_flags`, `alu_a`, `alu_b` are unchanged; `res_valid` stays 0.
